// File: rtl/afc_ncntr.sv
// afc_ncntr: counts fdiv_clk edges inside the afc measurement window and hands the
// result to the clk domain through a Gray-coded synchroniser.
module afc_ncntr #(
    parameter int CNT_W      = 14,
    parameter int SYNC_STG   = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fdiv_clk,
    input  logic             afc_cntr_rstn,
    input  logic             afc_cntr_en,
    input  logic             afc_cntr_datasyn,
    output logic [CNT_W-1:0] a2d_afc_ncntr,
    output logic             ncntr_valid,
    output logic             ncntr_ovf,
    output logic             cntr_busy
);
    localparam int TMR_N = SETTLE_CYC + SYNC_STG;
    localparam int TMR_W = $clog2(TMR_N + 1);
    localparam logic [CNT_W-1:0] ALL1 = '1;

    typedef enum logic [2:0] {IDLE, COUNT, DRAIN, SETTLE, DONE} state_t;

    logic [SYNC_STG-1:0] en_sf, clr_sf, ack_sc;
    logic [CNT_W-1:0]    gray_sc [SYNC_STG];
    logic [CNT_W-1:0]    cnt_f, cnt_nxt, gray_f, cnt_c;
    logic                en_f, clr_f, en_ack, load, pend;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    state_t              state, state_nxt;

    assign en_f    = en_sf[SYNC_STG-1];
    assign clr_f   = clr_sf[SYNC_STG-1];
    assign en_ack  = ack_sc[SYNC_STG-1];
    assign cnt_nxt = clr_f ? '0 : (en_f && cnt_f != ALL1) ? cnt_f + CNT_W'(1) : cnt_f;

    // Gray is taken from the next count so gray_f never lags the binary counter
    always_ff @(posedge fdiv_clk or negedge rstn)
        if (!rstn) begin
            en_sf  <= '0;
            clr_sf <= '0;
            cnt_f  <= '0;
            gray_f <= '0;
        end else begin
            en_sf  <= {en_sf[SYNC_STG-2:0], afc_cntr_en};
            clr_sf <= {clr_sf[SYNC_STG-2:0], ~afc_cntr_rstn};
            cnt_f  <= cnt_nxt;
            gray_f <= cnt_nxt ^ (cnt_nxt >> 1);
        end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ack_sc <= '0;
            for (int i = 0; i < SYNC_STG; i++) gray_sc[i] <= '0;
        end else begin
            ack_sc     <= {ack_sc[SYNC_STG-2:0], en_f};
            gray_sc[0] <= gray_f;
            for (int i = 1; i < SYNC_STG; i++) gray_sc[i] <= gray_sc[i-1];
        end

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < CNT_W; i++) cnt_c[i] = ^(gray_sc[SYNC_STG-1] >> i);
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            IDLE:   if (afc_cntr_en) state_nxt = COUNT;
            COUNT:  if (!afc_cntr_en) state_nxt = DRAIN;
            DRAIN:  if (!en_ack) begin
                        state_nxt = SETTLE;
                        tmr_nxt   = TMR_W'(TMR_N);
                    end
            SETTLE: if (tmr == '0) state_nxt = DONE;
                    else tmr_nxt = tmr - TMR_W'(1);
            DONE:   if (afc_cntr_en) state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
        if (!afc_cntr_rstn) state_nxt = IDLE;
    end

    assign cntr_busy = state inside {COUNT, DRAIN, SETTLE};
    assign load      = state == DONE && (afc_cntr_datasyn || pend);

    // The window clear outranks any load request in the same cycle
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state         <= IDLE;
            tmr           <= '0;
            pend          <= 1'b0;
            a2d_afc_ncntr <= '0;
            ncntr_valid   <= 1'b0;
            ncntr_ovf     <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (!afc_cntr_rstn) begin
                pend          <= 1'b0;
                a2d_afc_ncntr <= '0;
                ncntr_valid   <= 1'b0;
                ncntr_ovf     <= 1'b0;
            end else if (load) begin
                pend          <= 1'b0;
                a2d_afc_ncntr <= cnt_c;
                ncntr_valid   <= 1'b1;
                ncntr_ovf     <= cnt_c == ALL1;
            end else if (cntr_busy && afc_cntr_datasyn) begin
                pend <= 1'b1;
            end
        end
endmodule

// File: doc/afc_ncntr.md
# afc_ncntr

Digital frequency counter feeding the `afc` calibration FSM. It counts rising edges of the divided VCO clock `fdiv_clk` during the measurement window that `afc` frames with `afc_cntr_rstn` and `afc_cntr_en`. The count crosses into the `clk` domain through a Gray-coded synchroniser and is presented on `a2d_afc_ncntr` in response to `afc_cntr_datasyn`. It replaces the analog-side counter so that the AFC loop can run fully in digital.

## Interface
- CNT_W, 14, counter width; must match `afc` ncntr input.
- SYNC_STG, 2, flip-flop stages per synchroniser (min 2).
- SETTLE_CYC, 3, extra `clk` cycles waited after the count freezes, before the result is latchable.

Ports:
- clk  in  1  reference clock (`afc` domain).
- rstn  in  1  reset, asynchronous, active-low; clears both domains.
- fdiv_clk  in  1  divided VCO clock, asynchronous to clk.
- afc_cntr_rstn  in  1  active-low synchronous clear (clk domain) of the counter and result.
- afc_cntr_en  in  1  measurement window; high = count.
- afc_cntr_datasyn  in  1  single-cycle request to load the result.
- a2d_afc_ncntr  out  CNT_W  latched count; reset 0.
- ncntr_valid  out  1  high from result load until the next afc_cntr_rstn low; reset 0.
- ncntr_ovf  out  1  count saturated; registered with the result; reset 0.
- cntr_busy  out  1  high in COUNT/DRAIN/SETTLE; reset 0.

## Operation
- fdiv domain:
  - afc_cntr_en passes through a SYNC_STG synchroniser to give en_f.
  - The clear is a toggle-free level: afc_cntr_rstn low is synchronised to give clr_f.
  - The binary counter clears on clr_f. It increments on each fdiv_clk rising edge while en_f=1 and the count is below 2^CNT_W-1. It saturates at all-ones.
  - The counter is converted to Gray and registered into gray_f.
  - en_f is returned to the clk domain through a SYNC_STG synchroniser as en_ack.
- clk domain: gray_f passes through a SYNC_STG synchroniser, then Gray-to-binary conversion, giving cnt_c.
- FSM (clk domain):
  - IDLE: waits for afc_cntr_en=1, then goes to COUNT.
  - COUNT: goes to DRAIN when afc_cntr_en=0.
  - DRAIN: waits for en_ack=0, then goes to SETTLE with the timer loaded to SETTLE_CYC+SYNC_STG.
  - SETTLE: the timer decrements to 0, then the FSM goes to DONE.
  - DONE: returns to IDLE on afc_cntr_rstn=0. A new afc_cntr_en=1 goes to COUNT without clearing the counter (count accumulates).
- Result load:
  - In DONE, afc_cntr_datasyn=1 loads a2d_afc_ncntr<=cnt_c, ncntr_ovf<=(cnt_c==all-ones), and ncntr_valid<=1 on the next edge.
  - If datasyn arrives in COUNT/DRAIN/SETTLE, a pending flag is set and the load occurs on the first cycle in DONE.
- afc_cntr_rstn=0, in any state:
  - FSM goes to IDLE.
  - a2d_afc_ncntr, ncntr_valid, ncntr_ovf and the pending flag are cleared next edge.
  - The fdiv counter clears after synchronisation.
  - The clear has priority over a simultaneous datasyn.
- rstn low mid-window: all state is cleared immediately. After release, the block is in IDLE with count 0.

## Timing
- Counting starts SYNC_STG fdiv_clk edges after afc_cntr_en rises and stops SYNC_STG fdiv_clk edges after it falls. Count error is ±1 edge against the ideal window.
- Earliest load after afc_cntr_en falls: DRAIN (SYNC_STG fdiv edges + SYNC_STG clk edges), plus SETTLE_CYC+SYNC_STG clk edges, plus 1 clk edge.
- With fdiv_clk ≥ clk and defaults, that is ≤ 10 clk cycles. `afc` issues datasyn ≥ 10 cycles after dropping en; earlier requests are deferred, never lost.
- cnt_c only changes by one Gray step per fdiv edge. Its value is stable and exact in DONE.
- ncntr_valid rises in the same edge that a2d_afc_ncntr updates.

## Test plan
- Nominal window:
  - Stimulus: clk period 2 ns, fdiv_clk period 0.5 ns. afc_cntr_rstn pulse. en high 19 clk cycles. datasyn 12 cycles after en falls.
  - Response: a2d_afc_ncntr = 76±1, ncntr_valid=1, ncntr_ovf=0.
- Early datasyn:
  - Stimulus: datasyn 1 cycle after en falls, same setup as nominal.
  - Response: load deferred to the first DONE cycle. Value 76±1. busy low before valid rises.
- Saturation:
  - Stimulus: fdiv_clk period 0.25 ns, en high 64 clk cycles × 2 ns × 4 = 512 counts with CNT_W=8.
  - Response: result 255, ncntr_ovf=1.
- Clear priority:
  - Stimulus: afc_cntr_rstn=0 in the same cycle as datasyn in DONE.
  - Response: next edge a2d_afc_ncntr=0, valid=0. A following window counts from 0.
- Reset mid-count:
  - Stimulus: rstn low for 5 ns during COUNT, then en reasserted for 19 cycles.
  - Response: all outputs 0 during reset. Final result 76±1 (no residue from the first window).
- Asynchronous ratio sweep:
  - Stimulus: fdiv_clk period randomised in 0.3–3.7 ns, windows of 19 and 64 cycles, 200 iterations.
  - Response: every result within ±1 of window_time/fdiv_period. No X on outputs.
